// File: rtl/he_lb_copy_sched.sv
// he_lb_copy_sched: turns a programmed copy job into ordered line read and
// write requests, bounds in-flight lines to the loopback buffer depth, and
// closes each job with a single DSM status write.
`timescale 1ns/1ps
module he_lb_copy_sched #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned MAX_OUTST = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctl_start,
  input  logic              ctl_stop,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [CNT_W-1:0]  cfg_num_lines,
  input  logic [ADDR_W-1:0] cfg_dsm_base,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  output logic              wr_req_valid,
  input  logic              wr_req_ready,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic              wr_req_dsm,
  input  logic              wr_ack_valid,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              aborted,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DSM   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(MAX_OUTST);

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] src, src_n, dst, dst_n, dsm_base, dsm_base_n;
  logic [CNT_W-1:0]  num_lines, num_lines_n;
  logic [CNT_W-1:0]  rd_issued, rd_issued_n, wr_issued, wr_issued_n;
  logic [CNT_W-1:0]  num_reads_n, num_writes_n, pending_n;
  logic              dsm_sent, dsm_sent_n;
  logic              rd_hs, wr_hs;
  logic              rd_req_valid_n, wr_req_valid_n, wr_req_dsm_n;
  logic              busy_n, done_n, err_cfg_n, aborted_n;
  logic [ADDR_W-1:0] rd_req_addr_n, wr_req_addr_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Job registers, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src          <= '0;
      dst          <= '0;
      dsm_base     <= '0;
      num_lines    <= '0;
      rd_issued    <= '0;
      wr_issued    <= '0;
      num_reads    <= '0;
      num_writes   <= '0;
      dsm_sent     <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_dsm   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_cfg      <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      src          <= src_n;
      dst          <= dst_n;
      dsm_base     <= dsm_base_n;
      num_lines    <= num_lines_n;
      rd_issued    <= rd_issued_n;
      wr_issued    <= wr_issued_n;
      num_reads    <= num_reads_n;
      num_writes   <= num_writes_n;
      dsm_sent     <= dsm_sent_n;
      rd_req_valid <= rd_req_valid_n;
      rd_req_addr  <= rd_req_addr_n;
      wr_req_valid <= wr_req_valid_n;
      wr_req_addr  <= wr_req_addr_n;
      wr_req_dsm   <= wr_req_dsm_n;
      busy         <= busy_n;
      done         <= done_n;
      err_cfg      <= err_cfg_n;
      aborted      <= aborted_n;
    end
  end

  // Next-state, counter and output decode; outputs are built from next-cycle
  // counters so every response/ack is reflected one cycle later.
  always_comb begin
    state_n      = state;
    src_n        = src;
    dst_n        = dst;
    dsm_base_n   = dsm_base;
    num_lines_n  = num_lines;
    rd_issued_n  = rd_issued;
    wr_issued_n  = wr_issued;
    num_reads_n  = num_reads;
    num_writes_n = num_writes;
    dsm_sent_n   = dsm_sent;
    done_n       = done;
    err_cfg_n    = err_cfg;
    aborted_n    = aborted;
    rd_hs        = rd_req_valid && rd_req_ready;
    wr_hs        = wr_req_valid && wr_req_ready;

    case (state)
      S_IDLE, S_DONE: begin
        if (ctl_start) begin
          src_n        = cfg_src;
          dst_n        = cfg_dst;
          dsm_base_n   = cfg_dsm_base;
          num_lines_n  = cfg_num_lines;
          rd_issued_n  = '0;
          wr_issued_n  = '0;
          num_reads_n  = '0;
          num_writes_n = '0;
          dsm_sent_n   = 1'b0;
          aborted_n    = 1'b0;
          err_cfg_n    = (cfg_num_lines == '0);
          done_n       = (cfg_num_lines == '0);
          state_n      = (cfg_num_lines == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        if (rd_hs) rd_issued_n = rd_issued + CNT_W'(1);
        if (wr_hs) wr_issued_n = wr_issued + CNT_W'(1);
        // Excess responses/acks are dropped so counters never pass issued
        if (rd_rsp_valid && (num_reads < rd_issued))  num_reads_n  = num_reads + CNT_W'(1);
        if (wr_ack_valid && (num_writes < wr_issued)) num_writes_n = num_writes + CNT_W'(1);
        if (state == S_RUN) begin
          if (ctl_stop) begin
            state_n   = S_DRAIN;
            aborted_n = 1'b1;
          end else if (rd_issued_n == num_lines) begin
            state_n = S_DRAIN;
          end
        end else if ((num_writes_n == rd_issued_n) && (num_reads_n == wr_issued_n)) begin
          state_n = S_DSM;
        end
      end
      S_DSM: begin
        if (wr_hs) dsm_sent_n = 1'b1;
        // DSM ack closes the job and is not counted in num_writes
        if (wr_ack_valid && dsm_sent) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    pending_n      = num_reads_n - wr_issued_n;
    busy_n         = (state_n == S_RUN) || (state_n == S_DRAIN) || (state_n == S_DSM);
    rd_req_valid_n = (state_n == S_RUN) && (rd_issued_n < num_lines_n) &&
                     ((rd_issued_n - num_writes_n) < CREDITS);
    rd_req_addr_n  = src_n + ADDR_W'(rd_issued_n);
    wr_req_valid_n = 1'b0;
    wr_req_dsm_n   = 1'b0;
    wr_req_addr_n  = wr_req_addr;
    if (state_n == S_DSM) begin
      wr_req_valid_n = !dsm_sent_n;
      wr_req_dsm_n   = 1'b1;
      wr_req_addr_n  = dsm_base_n;
    end else if ((state_n == S_RUN) || (state_n == S_DRAIN)) begin
      wr_req_valid_n = (pending_n != '0);
      wr_req_addr_n  = dst_n + ADDR_W'(wr_issued_n);
    end
  end

endmodule

// File: tb/tb_he_lb_copy_sched.sv
// tb_he_lb_copy_sched: directed vector table plus hand sequences for credit
// stall, graceful stop, zero-length job and mid-job reset.
`timescale 1ns/1ps
module tb_he_lb_copy_sched;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned CNT_W     = 20;
  localparam int unsigned MAX_OUTST = 32;

  logic              clk;
  logic              rst;
  logic              ctl_start, ctl_stop;
  logic [ADDR_W-1:0] cfg_src, cfg_dst, cfg_dsm_base;
  logic [CNT_W-1:0]  cfg_num_lines;
  logic              rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [ADDR_W-1:0] rd_req_addr, wr_req_addr;
  logic              wr_req_valid, wr_req_ready, wr_req_dsm, wr_ack_valid;
  logic              busy, done, err_cfg, aborted;
  logic [CNT_W-1:0]  num_reads, num_writes;

  he_lb_copy_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst), .ctl_start(ctl_start), .ctl_stop(ctl_stop),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_num_lines(cfg_num_lines),
    .cfg_dsm_base(cfg_dsm_base), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .wr_req_valid(wr_req_valid),
    .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_dsm(wr_req_dsm), .wr_ack_valid(wr_ack_valid), .busy(busy),
    .done(done), .err_cfg(err_cfg), .aborted(aborted),
    .num_reads(num_reads), .num_writes(num_writes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] src, dst, dsm;
    int          n, lat;
    bit          rr;
    logic [63:0] exp_last_rd, exp_last_wr;
    int          exp_cnt;
  } vec_t;
  vec_t vecs[4];

  int checks = 0, errors = 0;
  int cyc = 0, rd_lat = 2, stop_at = 0, job_total = 0;
  bit rand_rdy = 0, hold_ack = 0;
  logic [63:0] j_src, j_dst, j_dsm, last_rd, last_wr;
  int rd_cnt, wr_cnt, acks, dsm_writes;
  int rd_due[$];
  int ack_due[$];
  bit ack_isdsm[$];
  bit prev_rsp, prev_ack_final, prev_ack_dsm, prev_rd_stall, prev_wr_stall, prev_wr_dsm;
  logic [63:0] prev_rd_addr, prev_wr_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    rd_due.delete(); ack_due.delete(); ack_isdsm.delete();
    rd_cnt = 0; wr_cnt = 0; acks = 0; dsm_writes = 0;
    prev_rsp = 0; prev_ack_final = 0; prev_ack_dsm = 0;
    prev_rd_stall = 0; prev_wr_stall = 0; prev_wr_dsm = 0;
    last_rd = '0; last_wr = '0;
  endtask

  // One clock: check outputs of the last edge, then drive inputs for the next
  task automatic cycle();
    bit rd_hs, wr_hs;
    @(negedge clk);
    cyc++;
    ctl_start = 0;
    ctl_stop  = 0;
    if (prev_rd_stall) begin
      chk("rd_valid_hold", rd_req_valid, 1);
      chk("rd_addr_hold", rd_req_addr, prev_rd_addr);
    end
    if (prev_wr_stall) begin
      chk("wr_valid_hold", wr_req_valid, 1);
      chk("wr_addr_hold", wr_req_addr, prev_wr_addr);
      chk("wr_dsm_hold", wr_req_dsm, prev_wr_dsm);
    end
    if (prev_rsp) chk("rsp_to_wr_valid", wr_req_valid, 1);
    if (prev_ack_final) begin
      chk("final_ack_dsm_valid", wr_req_valid, 1);
      chk("final_ack_dsm_flag", wr_req_dsm, 1);
    end
    if (prev_ack_dsm) begin
      chk("dsm_ack_done", done, 1);
      chk("dsm_ack_busy", busy, 0);
    end

    rd_req_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    wr_req_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    rd_rsp_valid = 0; prev_rsp = 0;
    if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
      rd_rsp_valid = 1; prev_rsp = 1;
      void'(rd_due.pop_front());
    end
    wr_ack_valid = 0; prev_ack_final = 0; prev_ack_dsm = 0;
    if (!hold_ack && ack_due.size() > 0 && ack_due[0] <= cyc) begin
      wr_ack_valid = 1;
      void'(ack_due.pop_front());
      if (ack_isdsm.pop_front()) prev_ack_dsm = 1;
      else begin
        acks++;
        if (acks == job_total) prev_ack_final = 1;
      end
    end

    rd_hs = rd_req_valid && rd_req_ready;
    wr_hs = wr_req_valid && wr_req_ready;
    if (rd_hs) begin
      chk("rd_addr", rd_req_addr, j_src + 64'(rd_cnt));
      last_rd = rd_req_addr;
      rd_cnt++;
      rd_due.push_back(cyc + rd_lat);
      if (stop_at != 0 && rd_cnt == stop_at) ctl_stop = 1;
    end
    if (wr_hs) begin
      if (wr_req_dsm) begin
        chk("dsm_addr", wr_req_addr, j_dsm);
        chk("dsm_after_acks", acks, rd_cnt);
        dsm_writes++;
        ack_isdsm.push_back(1);
      end else begin
        chk("wr_addr", wr_req_addr, j_dst + 64'(wr_cnt));
        last_wr = wr_req_addr;
        wr_cnt++;
        ack_isdsm.push_back(0);
      end
      ack_due.push_back(cyc + 1);
    end
    prev_rd_stall = rd_req_valid && !rd_req_ready;
    prev_rd_addr  = rd_req_addr;
    prev_wr_stall = wr_req_valid && !wr_req_ready;
    prev_wr_addr  = wr_req_addr;
    prev_wr_dsm   = wr_req_dsm;
  endtask

  task automatic start_job(input logic [63:0] src, input logic [63:0] dst,
                           input logic [63:0] dsm, input int n, input int lat, input bit rr);
    model_clear();
    j_src = src; j_dst = dst; j_dsm = dsm; rd_lat = lat; rand_rdy = rr; job_total = n;
    cfg_src = src; cfg_dst = dst; cfg_dsm_base = dsm; cfg_num_lines = CNT_W'(n);
    ctl_start = 1;
    cycle();
    chk("start_busy", busy, 1);
    chk("start_rd_valid", rd_req_valid, 1);
    chk("start_done_clr", done, 0);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      cycle();
      k++;
    end
    chk("job_done", done, 1);
  endtask

  initial begin
    vecs[0] = '{src:64'h100, dst:64'h200, dsm:64'h50, n:4, lat:2, rr:1'b0,
                exp_last_rd:64'h103, exp_last_wr:64'h203, exp_cnt:4};
    vecs[1] = '{src:64'hFFFF_FFFF_FFFF_FFFE, dst:64'h1000, dsm:64'h60, n:4, lat:3, rr:1'b1,
                exp_last_rd:64'h1, exp_last_wr:64'h1003, exp_cnt:4};
    vecs[2] = '{src:64'h7, dst:64'h10, dsm:64'h70, n:1, lat:1, rr:1'b0,
                exp_last_rd:64'h7, exp_last_wr:64'h10, exp_cnt:1};
    vecs[3] = '{src:64'h4000, dst:64'h8000, dsm:64'h80, n:40, lat:6, rr:1'b1,
                exp_last_rd:64'h4027, exp_last_wr:64'h8027, exp_cnt:40};

    rst = 1; ctl_start = 0; ctl_stop = 0;
    cfg_src = '0; cfg_dst = '0; cfg_dsm_base = '0; cfg_num_lines = '0;
    rd_req_ready = 0; wr_req_ready = 0; rd_rsp_valid = 0; wr_ack_valid = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_req_valid, 0);
    chk("rst_wr_valid", wr_req_valid, 0);
    chk("rst_counts", {num_reads, num_writes}, 0);
    rst = 0;

    // Table-driven jobs
    for (int i = 0; i < 4; i++) begin
      start_job(vecs[i].src, vecs[i].dst, vecs[i].dsm, vecs[i].n, vecs[i].lat, vecs[i].rr);
      wait_done(600);
      chk($sformatf("v%0d_num_reads", i), num_reads, vecs[i].exp_cnt);
      chk($sformatf("v%0d_num_writes", i), num_writes, vecs[i].exp_cnt);
      chk($sformatf("v%0d_last_rd", i), last_rd, vecs[i].exp_last_rd);
      chk($sformatf("v%0d_last_wr", i), last_wr, vecs[i].exp_last_wr);
      chk($sformatf("v%0d_dsm_writes", i), dsm_writes, 1);
      chk($sformatf("v%0d_flags", i), {busy, err_cfg, aborted}, 0);
    end

    // Zero-length job: error, immediate done, no traffic
    model_clear();
    rand_rdy = 0; cfg_num_lines = '0;
    ctl_start = 1;
    cycle();
    chk("zero_err_cfg", err_cfg, 1);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    for (int k = 0; k < 5; k++) begin
      chk("zero_no_rd", rd_req_valid, 0);
      chk("zero_no_wr", wr_req_valid, 0);
      cycle();
    end

    // Credit limit: acks withheld, reads stop at MAX_OUTST
    hold_ack = 1;
    start_job(64'h2_0000, 64'h3_0000, 64'hA0, 100, 2, 1'b0);
    chk("err_cfg_cleared", err_cfg, 0);
    repeat (60) cycle();
    chk("credit_reads", rd_cnt, MAX_OUTST);
    chk("credit_rd_valid", rd_req_valid, 0);
    chk("credit_writes", wr_cnt, MAX_OUTST);
    chk("credit_num_writes", num_writes, 0);
    hold_ack = 0;
    wait_done(800);
    chk("credit_num_reads_end", num_reads, 100);
    chk("credit_num_writes_end", num_writes, 100);
    chk("credit_rd_total", rd_cnt, 100);

    // Graceful stop on the tenth read handshake
    stop_at = 10;
    start_job(64'h5000, 64'h6000, 64'hB0, 50, 5, 1'b0);
    job_total = 10;
    wait_done(300);
    stop_at = 0;
    chk("stop_reads_issued", rd_cnt, 10);
    chk("stop_writes_issued", wr_cnt, 10);
    chk("stop_num_reads", num_reads, 10);
    chk("stop_num_writes", num_writes, 10);
    chk("stop_aborted", aborted, 1);
    chk("stop_dsm_writes", dsm_writes, 1);

    // Reset in the middle of a job
    start_job(64'h9000, 64'hA000, 64'hC0, 40, 3, 1'b0);
    repeat (15) cycle();
    rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valids", {rd_req_valid, wr_req_valid, wr_req_dsm}, 0);
    chk("midrst_addrs", rd_req_addr | wr_req_addr, 0);
    chk("midrst_counts", {num_reads, num_writes}, 0);
    chk("midrst_flags", {done, err_cfg, aborted}, 0);
    model_clear();
    rd_rsp_valid = 0; wr_ack_valid = 0;
    repeat (2) cycle();
    rst = 0;
    start_job(64'h3000, 64'h5000, 64'h90, 4, 2, 1'b0);
    wait_done(200);
    chk("post_rst_reads", num_reads, 4);
    chk("post_rst_writes", num_writes, 4);
    chk("post_rst_last_wr", last_wr, 64'h5003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/he_lb_copy_sched.md
# he_lb_copy_sched

Sequencing controller for the host-exercisor memory loopback engine. It converts the CSR-programmed copy job (source/destination line addresses, line count, DSM base, start/stop controls) into an ordered stream of line read requests and matching line write requests, and bounds in-flight lines to the loopback buffer depth. On completion it issues a single DSM status write and publishes read/write counters for the STATUS0 register. It sits between the CSR block and the memory request/response channels; payload data bypasses it.

## Interface
- ADDR_W, 64: line-address width (byte address >> 6).
- CNT_W, 20: width of line count and status counters.
- MAX_OUTST, 32: maximum lines read but not yet write-acked (buffer depth, power of 2, ≥2).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ctl_start  in  1  one-cycle pulse from CTL write; starts job.
- ctl_stop  in  1  one-cycle pulse; graceful abort.
- cfg_src  in  ADDR_W  first source line address.
- cfg_dst  in  ADDR_W  first destination line address.
- cfg_num_lines  in  CNT_W  lines to copy; 0 illegal.
- cfg_dsm_base  in  ADDR_W  DSM line address.
- rd_req_valid / rd_req_ready  out / in  1  read request handshake.
- rd_req_addr  out  ADDR_W  line to read.
- rd_rsp_valid  in  1  one line of read data returned (in order).
- wr_req_valid / wr_req_ready  out / in  1  write request handshake.
- wr_req_addr  out  ADDR_W  line to write.
- wr_req_dsm  out  1  current write is the DSM status write.
- wr_ack_valid  in  1  one write completed (in order).
- busy  out  1  job in progress.
- done  out  1  job finished; held until next start.
- err_cfg  out  1  start seen with cfg_num_lines == 0.
- aborted  out  1  last job ended by ctl_stop.
- num_reads, num_writes  out  CNT_W  lines read / write-acked in current job.

## Operation
- States: IDLE, RUN, DRAIN, DSM, DONE.
- IDLE/DONE + ctl_start: latch cfg_* into job registers; clear counters, done, aborted, err_cfg. If latched num_lines == 0: set err_cfg, go DONE with no traffic and no DSM write; else go RUN. ctl_start in RUN/DRAIN/DSM ignored.
- RUN: rd_req_valid while rd_issued < num_lines and (rd_issued − num_writes) < MAX_OUTST; rd_req_addr = src + rd_issued (mod 2^ADDR_W). Increment rd_issued per read handshake.
- Each rd_rsp_valid increments num_reads and the pending-write count. wr_req_valid while pending > 0; wr_req_addr = dst + wr_issued; wr_req_dsm = 0. Handshake decrements pending, increments wr_issued. wr_ack_valid increments num_writes.
- Simultaneous rd_rsp_valid and write handshake: pending unchanged.
- RUN → DRAIN when rd_issued == num_lines, or on ctl_stop (set aborted; stop new reads).
- DRAIN: keep writing pending lines; → DSM when num_writes == rd_issued and pending == 0.
- DSM: one write, wr_req_addr = dsm_base, wr_req_dsm = 1. On its ack (not counted in num_writes) → DONE: done = 1, busy = 0.
- ctl_stop in IDLE/DONE/DRAIN/DSM ignored beyond RUN semantics.
- rd_rsp_valid or wr_ack_valid in excess of outstanding count: ignored (counters saturate at issued values).
- Reset at any time: return to IDLE, all counters and flags cleared, in-flight traffic forgotten.

## Timing
- Reset values: all outputs 0; state IDLE.
- ctl_start at cycle T → busy = 1 and rd_req_valid = 1 at T+1 (registered).
- Issue rate: one read and one write per cycle each, sustained when ready and credits allow.
- rd_rsp_valid at T → wr_req_valid at T+1.
- Final ack at T → DSM write valid at T+1; DSM ack at T' → done = 1 at T'+1.
- valid/address held stable until ready; no valid retraction.
- Credit check uses registered counters; a write ack frees its credit in the next cycle.

## Test plan
- num_lines=4, src=0x100, dst=0x200, always ready → reads 0x100–0x103, writes 0x200–0x203, DSM write to dsm_base, done; num_reads=num_writes=4.
- num_lines=100, MAX_OUTST=32, withhold wr_ack → exactly 32 reads issued then rd_req_valid stalls; release acks → completes with 100/100.
- ctl_stop after 10 reads issued, 6 returned → no further reads, 10 writes drained, DSM write, done=1, aborted=1, num_writes=10.
- start with num_lines=0 → err_cfg=1, done=1 next cycle, no rd/wr valid.
- src=2^ADDR_W−2, num_lines=4 → read addresses wrap to 0,1; random ready backpressure keeps valid/addr stable.
- assert rst mid-RUN → all outputs 0 same cycle; new start runs cleanly.
